// File: rtl/psg_lpf_chain.sv
// psg_lpf_chain: cascade of first-order IIR low-pass stages for PSG audio.
// The unsigned sample is widened with fractional guard bits. Each stage
// computes y += (in - y) >>> K with K = shift+1, using floor rounding.
// Stage 0 runs every clock, stage 1 on a mid-rate enable, and stages 2+
// on a low-rate enable. The last stage is truncated back to DW bits.
// A bypass path forwards the registered input while the filters keep running.
module psg_lpf_chain #(
    parameter int DW    = 8,
    parameter int GUARD = 4,
    parameter int NSTG  = 4,
    parameter int DIV1  = 11,
    parameter int DIV2  = 101
) (
    input  logic          clk_27m,
    input  logic          reset_n,
    input  logic [DW-1:0] data_in,
    input  logic          bypass,
    input  logic [1:0]    shift,
    output logic [DW-1:0] data_out,
    output logic          out_stb
);

    localparam int IW  = DW + GUARD;
    localparam int C1W = (DIV1 > 2) ? $clog2(DIV1) : 1;
    localparam int C2W = (DIV2 > 2) ? $clog2(DIV2) : 1;

    logic [C1W-1:0] cnt1_reg;
    logic [C2W-1:0] cnt2_reg;
    logic           en1_reg;
    logic           en2_reg;
    logic [IW-1:0]  x0;
    logic [2:0]     k_w;
    logic [IW-1:0]  y_last;
    logic           upd_last;

    assign x0  = {data_in, {GUARD{1'b0}}};
    assign k_w = {1'b0, shift} + 3'd1;

    // Mid-rate enable: one-cycle pulse registered when the counter wraps.
    always_ff @(posedge clk_27m or negedge reset_n) begin
        if (!reset_n) begin
            cnt1_reg <= '0;
            en1_reg  <= 1'b0;
        end else if (cnt1_reg == C1W'(DIV1 - 1)) begin
            cnt1_reg <= '0;
            en1_reg  <= 1'b1;
        end else begin
            cnt1_reg <= cnt1_reg + C1W'(1);
            en1_reg  <= 1'b0;
        end
    end

    // Low-rate enable shared by stages 2 and above.
    always_ff @(posedge clk_27m or negedge reset_n) begin
        if (!reset_n) begin
            cnt2_reg <= '0;
            en2_reg  <= 1'b0;
        end else if (cnt2_reg == C2W'(DIV2 - 1)) begin
            cnt2_reg <= '0;
            en2_reg  <= 1'b1;
        end else begin
            cnt2_reg <= cnt2_reg + C2W'(1);
            en2_reg  <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : stg
            logic [IW-1:0]        y_reg;
            logic [IW-1:0]        in_w;
            logic                 en_w;
            logic signed [IW:0]   diff_w;
            logic signed [IW:0]   step_w;

            if (gi == 0) begin : g_first
                assign in_w = x0;
                assign en_w = 1'b1;
            end else begin : g_chain
                assign in_w = stg[gi-1].y_reg;
                assign en_w = (gi == 1) ? en1_reg : en2_reg;
            end

            // Difference is taken signed one bit wider; the arithmetic shift
            // floors toward minus infinity, so falling steps land exactly.
            assign diff_w = $signed({1'b0, in_w}) - $signed({1'b0, y_reg});
            assign step_w = diff_w >>> k_w;

            // Stage state update on its own enable; result stays in range.
            always_ff @(posedge clk_27m or negedge reset_n) begin
                if (!reset_n) begin
                    y_reg <= '0;
                end else if (en_w) begin
                    y_reg <= IW'($unsigned($signed({1'b0, y_reg}) + step_w));
                end
            end
        end

        assign y_last = stg[NSTG-1].y_reg;

        if (NSTG == 1) begin : g_stb_one
            // Stage 0 updates every clock, so every output is fresh.
            assign upd_last = 1'b1;
        end else begin : g_stb_many
            logic upd_reg;
            logic en_last;
            assign en_last = (NSTG == 2) ? en1_reg : en2_reg;

            // Delay the last-stage enable so the strobe lines up with data_out.
            always_ff @(posedge clk_27m or negedge reset_n) begin
                if (!reset_n) begin
                    upd_reg <= 1'b0;
                end else begin
                    upd_reg <= en_last;
                end
            end
            assign upd_last = upd_reg;
        end
    endgenerate

    // Output register: truncated last stage, or the input in bypass.
    always_ff @(posedge clk_27m or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            out_stb  <= 1'b0;
        end else begin
            data_out <= bypass ? data_in : y_last[IW-1:GUARD];
            out_stb  <= bypass ? 1'b1 : upd_last;
        end
    end

endmodule
